// File: rtl/cdb_broadcaster_pkg.sv
// Shared CDB definitions: producer tags, bus widths and the CDB payload type.
// Also imported by register_status and the reservation stations.
package cdb_defs;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned TAG_WIDTH  = 2;
  localparam int unsigned NUM_SRC    = 3;
  localparam int unsigned CNT_WIDTH  = 8;

  typedef logic [TAG_WIDTH-1:0]  tag_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam tag_t RES_STATION_ADD1 = 2'b00;
  localparam tag_t RES_STATION_ADD2 = 2'b01;
  localparam tag_t RES_STATION_MUL1 = 2'b10;
  localparam tag_t TAG_NONE         = 2'b11;

  // ADD1 holds first priority out of reset
  localparam logic [1:0] LAST_GRANT_RST = 2'd2;

  typedef struct packed {
    tag_t  tag;
    data_t data;
  } cdb_msg_t;

  // Source index reached by stepping 'step' places past 'last', modulo 3
  function automatic logic [1:0] rr_next(input logic [1:0] last, input logic [1:0] step);
    logic [2:0] sum;
    sum = 3'(last) + 3'(step);
    if (sum >= 3'd3) sum = sum - 3'd3;
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  function automatic tag_t src_tag(input logic [1:0] idx);
    case (idx)
      2'd0:    return RES_STATION_ADD1;
      2'd1:    return RES_STATION_ADD2;
      2'd2:    return RES_STATION_MUL1;
      default: return TAG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cdb_broadcaster_if.sv
// Source-result handshake and CDB broadcast bundle for cdb_broadcaster.
// master = functional-unit / listener side, slave = broadcaster.
interface cdb_broadcaster_if;
  import cdb_defs::*;

  logic [NUM_SRC-1:0]            Src_Valid;
  logic [NUM_SRC*DATA_WIDTH-1:0] Src_Data;
  logic [NUM_SRC-1:0]            Src_Ready;
  logic                          CDB_Valid;
  tag_t                          CDB_Tag;
  data_t                         CDB_Data;

  modport master (
    output Src_Valid, Src_Data,
    input  Src_Ready, CDB_Valid, CDB_Tag, CDB_Data
  );

  modport slave (
    input  Src_Valid, Src_Data,
    output Src_Ready, CDB_Valid, CDB_Tag, CDB_Data
  );

endinterface

// File: rtl/cdb_broadcaster_rr_arbiter3.sv
// rr_arbiter3: combinational 3-way round-robin arbiter.
// Searches last+1, last+2, last+3 (mod 3); the pointer register lives in the caller.
module rr_arbiter3
  import cdb_defs::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_grant_i,
  output logic [2:0] grant_o,
  output logic [1:0] grant_idx_o,
  output logic       any_grant_o
);

  logic [1:0] idx;
  logic       found;

  always_comb begin : arbitrate
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int unsigned k = 1; k <= 3; k++) begin
      idx = rr_next(last_grant_i, 2'(k));
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
    any_grant_o = found;
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common-data-bus broadcaster: one-entry holding buffer per source, round-robin
// grant, one registered tag+value broadcast per cycle. Option macro: CDB_PERF_EN.
module cdb_broadcaster
  import cdb_defs::*;
(
  input  logic               Clock,
  input  logic               Reset,
  cdb_broadcaster_if.slave   bus
`ifdef CDB_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] Conflict_Count
`endif
);

  logic [NUM_SRC-1:0]         full_q, full_d;
  data_t [NUM_SRC-1:0]        buf_q, buf_d;
  logic [1:0]                 last_grant_q, last_grant_d;
  logic                       cdb_valid_q, cdb_valid_d;
  cdb_msg_t                   cdb_q, cdb_d;

  logic [NUM_SRC-1:0]         accept;
  logic [NUM_SRC-1:0]         grant;
  logic [1:0]                 grant_idx;
  logic                       any_grant;
  data_t                      win_data;

  // Ready comes from registered state only, so no input-to-ready path exists
  assign bus.Src_Ready = ~full_q;
  assign accept        = bus.Src_Valid & ~full_q;

  rr_arbiter3 u_arb (
    .req_i        (full_q),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .any_grant_o  (any_grant)
  );

  always_comb begin : win_mux
    case (grant_idx)
      2'd0:    win_data = buf_q[0];
      2'd1:    win_data = buf_q[1];
      default: win_data = buf_q[2];
    endcase
  end

  // A granted buffer is full, so it never accepts on the same edge
  always_comb begin : next_state
    full_d       = full_q;
    buf_d        = buf_q;
    last_grant_d = last_grant_q;
    cdb_valid_d  = any_grant;
    cdb_d        = cdb_q;
    if (any_grant) begin
      full_d       = full_q & ~grant;
      last_grant_d = grant_idx;
      cdb_d.tag    = src_tag(grant_idx);
      cdb_d.data   = win_data;
    end
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (accept[i]) begin
        full_d[i] = 1'b1;
        buf_d[i]  = bus.Src_Data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin : state_reg
    if (Reset) begin
      full_q       <= '0;
      buf_q        <= '0;
      last_grant_q <= LAST_GRANT_RST;
      cdb_valid_q  <= 1'b0;
      cdb_q        <= '0;
    end else begin
      full_q       <= full_d;
      buf_q        <= buf_d;
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_q        <= cdb_d;
    end
  end

  assign bus.CDB_Valid = cdb_valid_q;
  assign bus.CDB_Tag   = cdb_q.tag;
  assign bus.CDB_Data  = cdb_q.data;

`ifdef CDB_PERF_EN
  logic [CNT_WIDTH-1:0] conflict_q, conflict_d;
  logic                 multi_full;

  assign multi_full = (full_q[0] & full_q[1]) | (full_q[0] & full_q[2]) | (full_q[1] & full_q[2]);

  // Saturating count of edges with two or more results competing
  always_comb begin : conflict_next
    conflict_d = conflict_q;
    if (multi_full && (conflict_q != {CNT_WIDTH{1'b1}})) begin
      conflict_d = conflict_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin : conflict_reg
    if (Reset) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign Conflict_Count = conflict_q;
`endif

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: directed scenarios plus random traffic
// checked against a per-cycle behavioural model of buffers and round-robin order.
module tb_cdb_broadcaster;

  logic Clock;
  logic Reset;
  int   errors;
  int   checks;

  cdb_broadcaster_if bus ();

`ifdef CDB_PERF_EN
  logic [7:0] conflict_count;
`endif

  cdb_broadcaster dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .bus            (bus)
`ifdef CDB_PERF_EN
    ,
    .Conflict_Count (conflict_count)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model state
  logic [2:0]  m_full;
  logic [15:0] m_data [3];
  int          m_last;
  logic        m_valid;
  logic [1:0]  m_tag;
  logic [15:0] m_cdata;
  int          m_conf;
  logic [2:0]  m_acc;

  task automatic model_reset();
    m_full  = 3'b000;
    for (int i = 0; i < 3; i++) m_data[i] = 16'h0;
    m_last  = 2;
    m_valid = 1'b0;
    m_tag   = 2'b00;
    m_cdata = 16'h0;
    m_conf  = 0;
    m_acc   = 3'b000;
  endtask

  // One clock: check ready, advance model across the edge, check CDB outputs
  task automatic step();
    int         win;
    int         nfull;
    logic [2:0] pre_full;
    checks++;
    if (bus.Src_Ready !== ~m_full) begin
      errors++;
      $display("FAIL src_ready: got %b expected %b", bus.Src_Ready, ~m_full);
    end
    @(posedge Clock);
    pre_full = m_full;
    win      = -1;
    nfull    = 0;
    for (int i = 0; i < 3; i++) if (m_full[i]) nfull++;
    for (int k = 1; k <= 3; k++) begin
      if (win < 0 && m_full[(m_last + k) % 3]) win = (m_last + k) % 3;
    end
    if (nfull >= 2 && m_conf < 255) m_conf++;
    if (win >= 0) begin
      m_valid      = 1'b1;
      m_tag        = 2'(win);
      m_cdata      = m_data[win];
      m_full[win]  = 1'b0;
      m_last       = win;
    end else begin
      m_valid = 1'b0;
    end
    m_acc = bus.Src_Valid & ~pre_full;
    for (int i = 0; i < 3; i++) begin
      if (m_acc[i]) begin
        m_full[i] = 1'b1;
        m_data[i] = bus.Src_Data[i*16 +: 16];
      end
    end
    @(negedge Clock);
    checks++;
    if (bus.CDB_Valid !== m_valid) begin
      errors++;
      $display("FAIL cdb_valid: got %b expected %b", bus.CDB_Valid, m_valid);
    end
    checks++;
    if (bus.CDB_Tag !== m_tag) begin
      errors++;
      $display("FAIL cdb_tag: got %b expected %b", bus.CDB_Tag, m_tag);
    end
    checks++;
    if (bus.CDB_Data !== m_cdata) begin
      errors++;
      $display("FAIL cdb_data: got %h expected %h", bus.CDB_Data, m_cdata);
    end
`ifdef CDB_PERF_EN
    checks++;
    if (conflict_count !== 8'(m_conf)) begin
      errors++;
      $display("FAIL conflict_count: got %0d expected %0d", conflict_count, m_conf);
    end
`endif
  endtask

  task automatic idle(input int n);
    bus.Src_Valid = 3'b000;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    Reset         = 1'b1;
    bus.Src_Valid = 3'b000;
    bus.Src_Data  = '0;
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    checks++;
    if (bus.Src_Ready !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 111", bus.Src_Ready);
    end
    checks++;
    if ({bus.CDB_Valid, bus.CDB_Tag, bus.CDB_Data} !== 19'h0) begin
      errors++;
      $display("FAIL reset_cdb: got %b/%b/%h expected 0/00/0000", bus.CDB_Valid, bus.CDB_Tag, bus.CDB_Data);
    end
    Reset = 1'b0;
  endtask

  task automatic test_all_three();
    bus.Src_Valid = 3'b111;
    bus.Src_Data  = {16'h000C, 16'h000B, 16'h000A};
    step();
    bus.Src_Valid = 3'b000;
    for (int j = 0; j < 3; j++) begin
      step();
      checks++;
      if (bus.CDB_Valid !== 1'b1 || bus.CDB_Tag !== 2'(j) || bus.CDB_Data !== 16'(16'hA + j)) begin
        errors++;
        $display("FAIL all_three[%0d]: got %b/%b/%h expected 1/%0d/%h", j, bus.CDB_Valid, bus.CDB_Tag, bus.CDB_Data, j, 16'hA + j);
      end
    end
    step();
  endtask

  task automatic test_single();
    bus.Src_Valid = 3'b001;
    bus.Src_Data  = {16'h0, 16'h0, 16'h1234};
    step();
    bus.Src_Valid = 3'b000;
    checks++;
    if (bus.Src_Ready !== 3'b110) begin
      errors++;
      $display("FAIL single_ready: got %b expected 110", bus.Src_Ready);
    end
    step();
    checks++;
    if (bus.CDB_Valid !== 1'b1 || bus.CDB_Tag !== 2'b00 || bus.CDB_Data !== 16'h1234) begin
      errors++;
      $display("FAIL single_bcast: got %b/%b/%h expected 1/00/1234", bus.CDB_Valid, bus.CDB_Tag, bus.CDB_Data);
    end
    step();
    checks++;
    if (bus.CDB_Valid !== 1'b0) begin
      errors++;
      $display("FAIL single_after: got %b expected 0", bus.CDB_Valid);
    end
  endtask

  task automatic test_rr_pointer();
    bus.Src_Valid = 3'b101;
    bus.Src_Data  = {16'h00C2, 16'h0, 16'h00A2};
    step();
    bus.Src_Valid = 3'b000;
    step();
    checks++;
    if (bus.CDB_Valid !== 1'b1 || bus.CDB_Tag !== 2'b10 || bus.CDB_Data !== 16'h00C2) begin
      errors++;
      $display("FAIL rr_first: got %b/%b/%h expected 1/10/00c2", bus.CDB_Valid, bus.CDB_Tag, bus.CDB_Data);
    end
    step();
    checks++;
    if (bus.CDB_Valid !== 1'b1 || bus.CDB_Tag !== 2'b00 || bus.CDB_Data !== 16'h00A2) begin
      errors++;
      $display("FAIL rr_second: got %b/%b/%h expected 1/00/00a2", bus.CDB_Valid, bus.CDB_Tag, bus.CDB_Data);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [15:0] val;
    logic [15:0] next_exp;
    int          bcasts;
    val      = 16'h5000;
    next_exp = 16'h5000;
    bcasts   = 0;
    bus.Src_Valid = 3'b010;
    for (int j = 1; j <= 20; j++) begin
      bus.Src_Data = {16'h0, val, 16'h0};
      step();
      if (m_acc[1]) val = val + 16'd1;
      checks++;
      if (bus.CDB_Valid !== ((j % 2) == 0)) begin
        errors++;
        $display("FAIL stream_valid[%0d]: got %b expected %b", j, bus.CDB_Valid, (j % 2) == 0);
      end
      if (bus.CDB_Valid === 1'b1) begin
        bcasts++;
        checks++;
        if (bus.CDB_Tag !== 2'b01 || bus.CDB_Data !== next_exp) begin
          errors++;
          $display("FAIL stream_order: got %b/%h expected 01/%h", bus.CDB_Tag, bus.CDB_Data, next_exp);
        end
        next_exp = next_exp + 16'd1;
      end
    end
    checks++;
    if (bcasts !== 10) begin
      errors++;
      $display("FAIL stream_count: got %0d expected 10", bcasts);
    end
    idle(3);
  endtask

  task automatic test_random();
    for (int j = 0; j < 300; j++) begin
      bus.Src_Valid = 3'($urandom_range(0, 7));
      bus.Src_Data  = {16'($urandom), 16'($urandom), 16'($urandom)};
      step();
    end
    idle(4);
  endtask

`ifdef CDB_PERF_EN
  task automatic test_conflict();
    bus.Src_Valid = 3'b111;
    for (int j = 0; j < 300; j++) begin
      bus.Src_Data = {16'($urandom), 16'($urandom), 16'($urandom)};
      step();
    end
    checks++;
    if (conflict_count !== 8'hFF) begin
      errors++;
      $display("FAIL conflict_sat: got %h expected ff", conflict_count);
    end
    for (int j = 0; j < 5; j++) step();
    checks++;
    if (conflict_count !== 8'hFF) begin
      errors++;
      $display("FAIL conflict_hold: got %h expected ff", conflict_count);
    end
    idle(4);
  endtask
`endif

  task automatic test_async_reset();
    bus.Src_Valid = 3'b011;
    bus.Src_Data  = {16'h0, 16'hBEEF, 16'hCAFE};
    step();
    bus.Src_Valid = 3'b000;
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (bus.CDB_Valid !== 1'b0 || bus.Src_Ready !== 3'b111) begin
      errors++;
      $display("FAIL async_reset: got valid=%b ready=%b expected 0/111", bus.CDB_Valid, bus.Src_Ready);
    end
    checks++;
    if (bus.CDB_Tag !== 2'b00 || bus.CDB_Data !== 16'h0) begin
      errors++;
      $display("FAIL async_reset_cdb: got %b/%h expected 00/0000", bus.CDB_Tag, bus.CDB_Data);
    end
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      checks++;
      if (bus.CDB_Valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_bcast[%0d]: got %b expected 0", j, bus.CDB_Valid);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_all_three();
    test_single();
    test_rr_pointer();
    test_back_to_back();
    test_random();
`ifdef CDB_PERF_EN
    test_conflict();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
